alu_multicycle: RTL and testbench

//  Next-generation execute-stage ALU. Width is a parameter. Single-cycle ops are registered.

---
 rtl/alu_multicycle_if.sv | 32 +++
 rtl/alu_multicycle.sv | 206 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - issue/result bundle between the ID/EX stage and the multicycle ALU
// master: drives start, opCode, in1, in2, shiftAmt; samples ready, valid, result, hi, lo,
//         overflow, zero, divByZero.
// slave:  the ALU side of the same signals.
interface alu_multicycle_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [3:0]         opCode;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [SHAMT_W-1:0] shiftAmt;
    logic               ready;
    logic               valid;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               overflow;
    logic               zero;
    logic               divByZero;

    modport master (
        output start, opCode, in1, in2, shiftAmt,
        input  ready, valid, result, hi, lo, overflow, zero, divByZero
    );

    modport slave (
        input  start, opCode, in1, in2, shiftAmt,
        output ready, valid, result, hi, lo, overflow, zero, divByZero
    );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - execute-stage ALU with registered 1-cycle ops and iterative mul/div
// clk   : rising-edge clock
// reset : asynchronous active-high reset
// bus   : alu_multicycle_if.slave (start/ready issue, one-cycle valid, result/hi/lo, flags)
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRA   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t state_q, state_d;

    logic [2*WIDTH-1:0] prod_q;      // mul: {accumulator, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opa_q;       // raw dividend, returned in hi on divide-by-zero
    logic [WIDTH-1:0]   opb_q;       // multiplicand or divisor magnitude
    logic               neg_q;       // product / quotient must be negated at the end
    logic               rneg_q;      // remainder takes the dividend's sign
    logic               dbz_q;
    logic               dovf_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q;
    logic               valid_q, ovf_q, zero_q, divbyzero_q;

    logic ready, accept, is_mul, is_div, op_signed, last;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign ready     = (state_q == IDLE);
    assign accept    = bus.start && ready;
    assign is_mul    = (bus.opCode == OP_MULT) || (bus.opCode == OP_MULTU);
    assign is_div    = (bus.opCode == OP_DIV) || (bus.opCode == OP_DIVU);
    assign op_signed = (bus.opCode == OP_MULT) || (bus.opCode == OP_DIV);
    assign mag_a     = (op_signed && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
    assign mag_b     = (op_signed && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
    assign last      = (cnt_q == SHAMT_W'(WIDTH-1));

    // single-cycle datapath
    logic [WIDTH-1:0] alu_res, alu_sum, alu_dif;
    logic             alu_ovf, alu_def;
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_def = 1'b1;
        alu_sum = bus.in1 + bus.in2;
        alu_dif = bus.in1 - bus.in2;
        case (bus.opCode)
            OP_AND:  alu_res = bus.in1 & bus.in2;
            OP_OR:   alu_res = bus.in1 | bus.in2;
            OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                          (alu_sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = alu_dif;
                alu_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                          (alu_dif[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SLL:  alu_res = bus.in1 << bus.shiftAmt;
            OP_SRL:  alu_res = bus.in1 >> bus.shiftAmt;
            OP_SRA:  alu_res = $unsigned($signed(bus.in1) >>> bus.shiftAmt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            default: alu_def = 1'b0;
        endcase
    end

    // one shift-add step; the last step also folds in the sign correction
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_final;
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_final = neg_q ? -mul_next : mul_next;

    // one restoring-division step: shift in the next dividend bit, trial-subtract
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_rem, div_quo, rem_fin, quo_fin;
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_quo   = {prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
    assign rem_fin   = rneg_q ? -div_rem : div_rem;
    assign quo_fin   = neg_q ? -div_quo : div_quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul)      state_d = MUL;
                else if (accept && is_div) state_d = DIV;
            end
            MUL, DIV: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            dbz_q       <= 1'b0;
            dovf_q      <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            divbyzero_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    cnt_q <= '0;
                    neg_q <= op_signed && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
                    if (is_mul) begin
                        opb_q  <= mag_a;
                        prod_q <= {{WIDTH{1'b0}}, mag_b};
                    end else if (is_div) begin
                        opa_q  <= bus.in1;
                        opb_q  <= mag_b;
                        prod_q <= {{WIDTH{1'b0}}, mag_a};
                        rneg_q <= op_signed && bus.in1[WIDTH-1];
                        dbz_q  <= (bus.in2 == '0);
                        dovf_q <= op_signed && (bus.in1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                  (bus.in2 == '1);
                    end else begin
                        result_q <= alu_res;
                        zero_q   <= alu_def && (alu_res == '0);
                        ovf_q    <= alu_ovf;
                        valid_q  <= 1'b1;
                    end
                end
                MUL: begin
                    cnt_q  <= cnt_q + 1'b1;
                    prod_q <= mul_next;
                    if (last) begin
                        hi_q     <= mul_final[2*WIDTH-1:WIDTH];
                        lo_q     <= mul_final[WIDTH-1:0];
                        result_q <= mul_final[WIDTH-1:0];
                        zero_q   <= (mul_final[WIDTH-1:0] == '0);
                        ovf_q    <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                DIV: begin
                    cnt_q  <= cnt_q + 1'b1;
                    prod_q <= {div_rem, div_quo};
                    if (last) begin
                        if (dbz_q) begin
                            hi_q     <= opa_q;
                            lo_q     <= '1;
                            result_q <= '1;
                            zero_q   <= 1'b0;
                        end else begin
                            hi_q     <= rem_fin;
                            lo_q     <= quo_fin;
                            result_q <= quo_fin;
                            zero_q   <= (quo_fin == '0);
                        end
                        ovf_q       <= dovf_q;
                        divbyzero_q <= dbz_q;
                        valid_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = ready;
    assign bus.valid     = valid_q;
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.divByZero = divbyzero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
module tb_alu_multicycle;
    localparam int W  = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    alu_multicycle_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
    alu_multicycle #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          muldiv;
        bit          isdiv;
        logic [31:0] res, hi, lo;
        logic        zero, ovf, dbz;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_due = 0;
    bit   chk_en = 1'b0;
    exp_t q[$];
    logic [31:0] e_res = '0, e_hi = '0, e_lo = '0;
    logic        e_zero = 1'b0, e_ovf = 1'b0, e_dbz = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t e;
        logic signed [63:0] sa, sb, s, r;
        logic [63:0] ua, ub, u;
        e = '{default: 0};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'hC: e.res = ~(a | b);
            4'h2: begin s = sa + sb; e.res = s[31:0];
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h6: begin s = sa - sb; e.res = s[31:0];
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h3: begin s = sa >>> sh; e.res = s[31:0]; end
            4'h4: e.res = a << sh;
            4'h5: e.res = a >> sh;
            4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: e.res = (a < b) ? 32'd1 : 32'd0;
            4'h9: begin s = sa * sb; e.hi = s[63:32]; e.lo = s[31:0]; e.muldiv = 1; end
            4'hA: begin u = ua * ub; e.hi = u[63:32]; e.lo = u[31:0]; e.muldiv = 1; end
            4'hB, 4'hD: begin
                e.muldiv = 1;
                e.isdiv  = 1;
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dbz = 1;
                end else if (op == 4'hB) begin
                    s = sa / sb; r = sa % sb;
                    e.lo = s[31:0]; e.hi = r[31:0];
                    e.ovf = (s > 64'sd2147483647);
                end else begin
                    u = ua / ub; e.lo = u[31:0];
                    u = ua % ub; e.hi = u[31:0];
                end
            end
            default: e.res = '0;
        endcase
        if (e.muldiv) e.res = e.lo;
        e.zero = (op <= 4'hD) && (e.res == 0);
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        busy_due = 0;
        e_res = '0; e_hi = '0; e_lo = '0;
        e_zero = 0; e_ovf = 0; e_dbz = 0;
    endtask

    task automatic check_cycle();
        exp_t e;
        bit   ev;
        ev = 0;
        while (q.size() > 0 && q[0].due < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_valid: expected completion at cycle %0d never seen", q[0].due);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            ev = 1;
            e_res = e.res; e_zero = e.zero; e_ovf = e.ovf;
            if (e.muldiv) begin e_hi = e.hi; e_lo = e.lo; end
            if (e.isdiv) e_dbz = e.dbz;
        end
        cmp("valid", bus.valid, ev);
        cmp("ready", bus.ready, !(cyc < busy_due));
        cmp("result", bus.result, e_res);
        cmp("zero", bus.zero, e_zero);
        cmp("overflow", bus.overflow, e_ovf);
        cmp("hi", bus.hi, e_hi);
        cmp("lo", bus.lo, e_lo);
        cmp("divByZero", bus.divByZero, e_dbz);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (chk_en) check_cycle();
    end

    // Called at a negedge; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        exp_t e;
        bus.start = 1'b1; bus.opCode = op; bus.in1 = a; bus.in2 = b; bus.shiftAmt = sh;
        if (!(cyc < busy_due)) begin
            e = model(op, a, b, sh);
            e.due = cyc + 1 + (e.muldiv ? 32 : 0);
            if (e.muldiv) busy_due = e.due;
            q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(op, a, b, 5'd0);
        n = 0;
        while (!bus.valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL md_timeout: op %h no valid within 60 cycles", op);
        end
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a, b; logic [4:0] sh; } vec_t;
    vec_t vecs[$];
    int lowcnt, cnt;

    initial begin
        bus.start = 0; bus.opCode = 0; bus.in1 = 0; bus.in2 = 0; bus.shiftAmt = 0;
        chk_en = 1;
        repeat (3) @(negedge clk);
        cmp("rst_ready", bus.ready, 1);
        cmp("rst_valid", bus.valid, 0);
        cmp("rst_result", bus.result, 0);
        reset = 0;
        @(negedge clk);

        issue(4'h2, 32'h7FFFFFFF, 32'h1, 0);
        cmp("add_valid", bus.valid, 1);
        cmp("add_result", bus.result, 32'h80000000);
        cmp("add_ovf", bus.overflow, 1);
        cmp("add_zero", bus.zero, 0);

        issue(4'h3, 32'hFFFFFFF0, 32'h0, 5'd2);
        cmp("sra_result", bus.result, 32'hFFFFFFFC);
        issue(4'h8, 32'h1, 32'hFFFFFFFF, 0);
        cmp("sltu_result", bus.result, 32'h1);
        cmp("sltu_valid", bus.valid, 1);
        issue(4'h6, 32'd5, 32'd5, 0);
        cmp("sub_result", bus.result, 32'h0);
        cmp("sub_zero", bus.zero, 1);

        vecs = '{
            '{4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0},
            '{4'h1, 32'hF000_0000, 32'h0000_000F, 5'd0},
            '{4'hC, 32'hF000_0000, 32'h0000_000F, 5'd0},
            '{4'h4, 32'h8000_0001, 32'h0, 5'd31},
            '{4'h5, 32'h8000_0000, 32'h0, 5'd31},
            '{4'h3, 32'h8000_0000, 32'h0, 5'd31},
            '{4'h7, 32'hFFFF_FFFF, 32'h1, 5'd0},
            '{4'h8, 32'hFFFF_FFFF, 32'h1, 5'd0},
            '{4'h6, 32'h8000_0000, 32'h1, 5'd0},
            '{4'h2, 32'hFFFF_FFFF, 32'h1, 5'd0},
            '{4'h1, 32'h0000_0001, 32'h0, 5'd0},
            '{4'hE, 32'h0000_0000, 32'h0, 5'd0},
            '{4'hF, 32'h1234_5678, 32'h1, 5'd0}
        };
        foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
        cmp("undef_zero", bus.zero, 0);
        cmp("undef_result", bus.result, 0);
        @(negedge clk);

        issue(4'h9, 32'hFFFFFFFD, 32'd7, 0);
        lowcnt = 0;
        cnt = 0;
        while (!bus.valid && cnt < 100) begin
            if (!bus.ready) lowcnt++;
            if (cnt == 5 || cnt == 6) issue(4'h2, 32'd1, 32'd1, 0);
            else @(negedge clk);
            cnt++;
        end
        cmp("mult_ready_low_cycles", lowcnt, 32);
        cmp("mult_ready_at_valid", bus.ready, 1);
        cmp("mult_hi", bus.hi, 32'hFFFFFFFF);
        cmp("mult_lo", bus.lo, 32'hFFFFFFEB);
        cmp("mult_result", bus.result, 32'hFFFFFFEB);

        run_md(4'hB, 32'hFFFFFFF9, 32'd2);
        cmp("div_lo", bus.lo, 32'hFFFFFFFD);
        cmp("div_hi", bus.hi, 32'hFFFFFFFF);
        run_md(4'hD, 32'd7, 32'd0);
        cmp("divu0_lo", bus.lo, 32'hFFFFFFFF);
        cmp("divu0_hi", bus.hi, 32'd7);
        cmp("divu0_dbz", bus.divByZero, 1);
        issue(4'h0, 32'hFFFF, 32'hFF, 0);
        cmp("hold_hi", bus.hi, 32'd7);
        run_md(4'hB, 32'h80000000, 32'hFFFFFFFF);
        cmp("divmin_lo", bus.lo, 32'h80000000);
        cmp("divmin_hi", bus.hi, 32'h0);
        cmp("divmin_ovf", bus.overflow, 1);
        cmp("divmin_dbz", bus.divByZero, 0);
        run_md(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cmp("multu_hi", bus.hi, 32'hFFFFFFFE);
        cmp("multu_lo", bus.lo, 32'h1);
        run_md(4'h9, 32'h80000000, 32'h80000000);
        cmp("multmin_hi", bus.hi, 32'h40000000);
        run_md(4'hB, 32'd7, 32'hFFFFFFFE);
        cmp("div_neg_divisor_lo", bus.lo, 32'hFFFFFFFD);
        cmp("div_neg_divisor_hi", bus.hi, 32'd1);
        run_md(4'hD, 32'hFFFFFFFF, 32'd10);
        run_md(4'hB, 32'hFFFFFFF9, 32'd0);
        run_md(4'h9, 32'd0, 32'h12345678);
        issue(4'h2, 32'd3, 32'd4, 0);

        issue(4'h9, 32'd5, 32'd6, 0);
        repeat (10) @(negedge clk);
        #2;
        reset = 1;
        model_reset();
        @(negedge clk);
        cmp("midrst_ready", bus.ready, 1);
        cmp("midrst_hi", bus.hi, 0);
        cmp("midrst_lo", bus.lo, 0);
        cmp("midrst_valid", bus.valid, 0);
        reset = 0;
        repeat (40) @(negedge clk);
        issue(4'h6, 32'd1, 32'd2, 0);
        cmp("post_rst_sub", bus.result, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
